// File: rtl/alarm_ringer.sv
// Alarm ring controller: detects the rising edge of time == alarm time and runs
// the ring / snooze / timeout sequence that drives the alarm LED and status flags.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a fresh match of current time against alarm
//   S_RINGING | LED blinking, counting down the ring timeout
//   S_SNOOZE  | LED dark, counting down the snooze interval
module alarm_ringer #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sec_tick,
   input  logic       i_armed,
   input  logic [3:0] i_ht,
   input  logic [3:0] i_hu,
   input  logic [3:0] i_mt,
   input  logic [3:0] i_mu,
   input  logic [3:0] i_al_ht,
   input  logic [3:0] i_al_hu,
   input  logic [3:0] i_al_mt,
   input  logic [3:0] i_al_mu,
   input  logic       i_snooze,
   input  logic       i_dismiss,
   output logic       o_ring,
   output logic       o_ringing,
   output logic       o_snoozing,
   output logic [1:0] o_snooze_cnt
);

   localparam int CNT_TOP = ((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC) - 1;
   localparam int CW      = (CNT_TOP < 2) ? 1 : $clog2(CNT_TOP + 1);

   localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC - 1);
   localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC - 1);
   localparam logic [1:0]    SNZ_LIMIT   = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RINGING = 2'd1,
      S_SNOOZE  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_sec_left;
   logic [CW-1:0]   w_sec_left_nxt;
   logic            r_phase;
   logic            w_phase_nxt;
   logic [1:0]      r_snooze_cnt;
   logic [1:0]      w_snooze_cnt_nxt;
   logic            r_eq_q;
   logic            r_ring;
   logic            r_ringing;
   logic            r_snoozing;

   logic            w_eq;
   logic            w_nz;
   logic            w_trigger;
   logic            w_sec_done;

   assign w_eq       = ({i_ht, i_hu, i_mt, i_mu} == {i_al_ht, i_al_hu, i_al_mt, i_al_mu});
   assign w_nz       = |{i_al_ht, i_al_hu, i_al_mt, i_al_mu};
   assign w_trigger  = w_eq & ~r_eq_q & i_armed & w_nz;
   assign w_sec_done = (r_sec_left == '0);

   // Timers count down from (interval-1); a tick seen at zero ends the interval.
   always_comb begin
      w_state_nxt      = r_state;
      w_sec_left_nxt   = r_sec_left;
      w_phase_nxt      = r_phase;
      w_snooze_cnt_nxt = r_snooze_cnt;

      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_state_nxt      = S_RINGING;
               w_sec_left_nxt   = RING_LOAD;
               w_phase_nxt      = 1'b1;
               w_snooze_cnt_nxt = 2'd0;
            end
         end
         S_RINGING: begin
            if (!i_armed || i_dismiss) begin
               w_state_nxt = S_IDLE;
            end else if (i_snooze) begin
               if (r_snooze_cnt < SNZ_LIMIT) begin
                  w_state_nxt      = S_SNOOZE;
                  w_sec_left_nxt   = SNOOZE_LOAD;
                  w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (i_sec_tick) begin
               if (w_sec_done) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_sec_left_nxt = r_sec_left - CW'(1);
                  w_phase_nxt    = ~r_phase;
               end
            end
         end
         S_SNOOZE: begin
            if (!i_armed || i_dismiss) begin
               w_state_nxt = S_IDLE;
            end else if (i_sec_tick) begin
               if (w_sec_done) begin
                  w_state_nxt    = S_RINGING;
                  w_sec_left_nxt = RING_LOAD;
                  w_phase_nxt    = 1'b1;
               end else begin
                  w_sec_left_nxt = r_sec_left - CW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_state_nxt == S_IDLE) begin
         w_sec_left_nxt   = '0;
         w_phase_nxt      = 1'b0;
         w_snooze_cnt_nxt = 2'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_sec_left   <= '0;
         r_phase      <= 1'b0;
         r_snooze_cnt <= 2'd0;
         r_eq_q       <= 1'b0;
         r_ring       <= 1'b0;
         r_ringing    <= 1'b0;
         r_snoozing   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sec_left   <= w_sec_left_nxt;
         r_phase      <= w_phase_nxt;
         r_snooze_cnt <= w_snooze_cnt_nxt;
         r_eq_q       <= w_eq;
         r_ring       <= (w_state_nxt == S_RINGING) & w_phase_nxt;
         r_ringing    <= (w_state_nxt == S_RINGING);
         r_snoozing   <= (w_state_nxt == S_SNOOZE);
      end
   end

   assign o_ring       = r_ring;
   assign o_ringing    = r_ringing;
   assign o_snoozing   = r_snoozing;
   assign o_snooze_cnt = r_snooze_cnt;

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Alarm ring controller that sits directly downstream of the time-keeping and alarm-setting stages. It compares the running HH:MM digits against the stored alarm digits and raises a one-shot trigger when they first become equal. It then runs a ring / snooze / timeout state machine and drives the blinking alarm LED plus status flags to the top level. This replaces the ad-hoc combinational ring logic in the top level with a registered, edge-triggered controller.

## Interface
- RING_SEC, 60: seconds the alarm rings before it auto-stops.
- SNOOZE_SEC, 300: seconds spent in snooze before ringing resumes.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse once per second, from the clock divider
- armed  in  1  alarm enabled; high while the design is in clock (not adjust) mode
- HT, HU, MT, MU  in  4 each  current time, BCD hour tens/units, minute tens/units
- al_HT, al_HU, al_MT, al_MU  in  4 each  alarm time, BCD
- snooze  in  1  one-cycle debounced button pulse
- dismiss  in  1  one-cycle debounced button pulse
- ring  out  1  blinking alarm LED drive
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- snooze_cnt  out  2  snoozes used in the current alarm event

## Operation
- eq = all four current digits equal the alarm digits; nz = alarm time is not 00:00 (00:00 means the alarm is disabled).
- eq_q is eq registered once per cycle; reset value 0.
- trigger = eq & ~eq_q & armed & nz. The trigger fires only on the rising edge of equality; asserting armed in the middle of a matching minute does not trigger.
- States: IDLE, RINGING, SNOOZE.
- IDLE: on trigger, go to RINGING; sec_cnt=0, phase=1, snooze_cnt=0.
- RINGING, priority dismiss > snooze > timeout:
  - dismiss -> IDLE.
  - snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE; sec_cnt=0, snooze_cnt+1.
  - snooze with snooze_cnt == MAX_SNOOZE -> IDLE (treated as dismiss).
  - sec_tick with sec_cnt == RING_SEC-1 -> IDLE.
  - Any other sec_tick: sec_cnt+1, phase toggles.
- SNOOZE:
  - dismiss -> IDLE.
  - sec_tick with sec_cnt == SNOOZE_SEC-1 -> RINGING; sec_cnt=0, phase=1.
  - Other sec_tick: sec_cnt+1.
  - snooze pulses are ignored.
- armed low in RINGING or SNOOZE -> IDLE. This has priority over all other events.
- trigger outside IDLE is ignored.
- Changing the alarm digits after a trigger does not affect the current event.
- snooze_cnt clears to 0 on entry to IDLE.
- sec_cnt is wide enough for max(RING_SEC, SNOOZE_SEC)-1 and never wraps.
- ring = (state==RINGING) & phase. ringing and snoozing decode the state.
- All outputs are registered.

## Timing
- Reset: state IDLE; ring, ringing, snoozing, snooze_cnt, sec_cnt, phase and eq_q all 0.
- Digits change at cycle N -> eq_q updates at N+1; trigger is evaluated at N; ringing=1 and ring=1 at N+1.
- Button pulse at cycle N -> state change visible at N+1.
- sec_tick at N -> counter and phase update visible at N+1.
- A ring event lasting the full timeout is exactly RING_SEC sec_ticks long, counted from the first tick after entry.
- Simultaneous dismiss and sec_tick at the timeout edge -> IDLE. The result is the same either way.
- Simultaneous snooze and the timeout tick with snooze_cnt < MAX_SNOOZE -> SNOOZE (snooze wins).
- rst asserted in any state -> reset values at the next edge. No trigger occurs on the first cycle after reset unless eq rises later, except that eq=1 at release with armed & nz triggers, because eq_q resets to 0.

## Test plan
- Alarm 07:30, armed=1, time steps 07:29 -> 07:30:
  - Required: ringing=1 one cycle after the step.
  - Required: ring toggles on each sec_tick.
  - Required: after 60 ticks ringing=0; it does not re-ring while the time stays at 07:30.
- Alarm 00:00, time 00:00 after reset, armed=1 -> ringing stays 0 indefinitely.
- Ringing, snooze pulse:
  - Required: snoozing=1 and snooze_cnt=1.
  - Required: after 300 ticks ringing=1 and ring=1.
  - Repeat to snooze_cnt=3; a 4th snooze -> IDLE with snooze_cnt=0.
- Ringing, dismiss and snooze in the same cycle -> IDLE, snooze_cnt=0.
- Ringing, then armed drops to 0 -> IDLE next cycle. Re-asserting armed within the same matching minute -> no ring.
- Snoozing, rst pulse mid-countdown -> all outputs 0 next cycle. A later 07:29 -> 07:30 edge rings normally.
